// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC control-register arbiter.
// Imported by mac_ctrl_arb.
package mac_ctrl_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ISSUE
    } state_e;

    localparam int MAC_ADDR_W = 8;
    localparam int MAC_DATA_W = 32;

    localparam logic [MAC_DATA_W-1:0] ERR_DATA_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first pending index after i_last, with wrap.
// Shared by arbiters that keep their own last-grant register.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_pending,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    int j;

    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        j       = 0;
        for (int i = 1; i <= N; i++) begin
            j = int'(i_last) + i;
            if (j >= N) j = j - N;
            if (!o_valid && i_pending[IDX_W'(j)]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mac_ctrl_arb.sv
// Round-robin arbiter sharing the MAC control/status register port
// between register masters, with a waitrequest timeout abort.
module mac_ctrl_arb
    import mac_ctrl_pkg::*;
#(
    parameter int                N_REQ    = 2,
    parameter int                ADDR_W   = MAC_ADDR_W,
    parameter int                DATA_W   = MAC_DATA_W,
    parameter int                TIMEOUT  = 1023,
    parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
    input  logic [N_REQ*DATA_W-1:0] i_req_wr_data,
    input  logic [N_REQ-1:0]        i_req_wr,
    input  logic [N_REQ-1:0]        i_req_rd,
    output logic [DATA_W-1:0]       o_req_rd_data,
    output logic [N_REQ-1:0]        o_req_waitrequest,
    output logic [ADDR_W-1:0]       o_mac_addr,
    output logic [DATA_W-1:0]       o_mac_wr_data,
    output logic                    o_mac_wr,
    output logic                    o_mac_rd,
    input  logic [DATA_W-1:0]       i_mac_rd_data,
    input  logic                    i_mac_waitrequest,
    output logic                    o_busy,
    output logic                    o_timeout
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] pend;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;
    logic             g_wr;
    logic             g_rd;

    assign pend = i_req_rd | i_req_wr;
    assign g_wr = i_req_wr[grant_q];
    assign g_rd = i_req_rd[grant_q];

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_pending (pend),
        .i_last    (last_q),
        .o_idx     (pick_idx),
        .o_valid   (pick_vld)
    );

    always_comb begin
        state_d           = state_q;
        grant_d           = grant_q;
        last_d            = last_q;
        cnt_d             = cnt_q;
        o_req_waitrequest = '1;
        o_req_rd_data     = '0;
        o_mac_addr        = '0;
        o_mac_wr_data     = '0;
        o_mac_wr          = 1'b0;
        o_mac_rd          = 1'b0;
        o_timeout         = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_idx;
                    cnt_d   = '0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_mac_addr    = i_req_addr[int'(grant_q)*ADDR_W +: ADDR_W];
                o_mac_wr_data = i_req_wr_data[int'(grant_q)*DATA_W +: DATA_W];
                o_mac_wr      = g_wr;
                o_mac_rd      = g_rd & ~g_wr;
                // Completion beats a same-cycle withdrawal.
                if (!i_mac_waitrequest) begin
                    o_req_waitrequest[grant_q] = 1'b0;
                    o_req_rd_data = i_mac_rd_data;
                    last_d        = grant_q;
                    state_d       = ST_IDLE;
                end else if (cnt_q == TO_LIM) begin
                    o_mac_wr      = 1'b0;
                    o_mac_rd      = 1'b0;
                    o_req_waitrequest[grant_q] = 1'b0;
                    o_req_rd_data = ERR_DATA;
                    o_timeout     = 1'b1;
                    last_d        = grant_q;
                    state_d       = ST_IDLE;
                end else if (!(g_rd | g_wr)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_busy = (state_q == ST_ISSUE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            last_q  <= LAST_RST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mac_ctrl_arb.sv
// Self-checking bench for mac_ctrl_arb: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mac_ctrl_arb;

    localparam int N  = 2;
    localparam int TO = 15;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*8-1:0]  req_addr = '0;
    logic [N*32-1:0] req_wdata = '0;
    logic [N-1:0]    req_wr = '0;
    logic [N-1:0]    req_rd = '0;
    logic [31:0]     rd_data;
    logic [N-1:0]    wreq;
    logic [7:0]      mac_addr;
    logic [31:0]     mac_wdata;
    logic            mac_wr;
    logic            mac_rd;
    logic [31:0]     mac_rdata = '0;
    logic            mac_wait = 1'b1;
    logic            busy;
    logic            tmo;

    mac_ctrl_arb #(
        .N_REQ    (N),
        .ADDR_W   (8),
        .DATA_W   (32),
        .TIMEOUT  (TO),
        .ERR_DATA (ERR)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_req_addr        (req_addr),
        .i_req_wr_data     (req_wdata),
        .i_req_wr          (req_wr),
        .i_req_rd          (req_rd),
        .o_req_rd_data     (rd_data),
        .o_req_waitrequest (wreq),
        .o_mac_addr        (mac_addr),
        .o_mac_wr_data     (mac_wdata),
        .o_mac_wr          (mac_wr),
        .o_mac_rd          (mac_rd),
        .i_mac_rd_data     (mac_rdata),
        .i_mac_waitrequest (mac_wait),
        .o_busy            (busy),
        .o_timeout         (tmo)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference model: who owns the port, how long it has waited.
    bit   m_issue = 0;
    int   m_g = 0;
    int   m_wait = 0;
    int   m_last = N - 1;

    logic [N-1:0] pend, e_wreq;
    logic [31:0]  e_rd, e_wd;
    logic [7:0]   e_addr;
    logic         e_wr, e_mrd, e_busy, e_to;

    // Event log from DUT observations.
    int          glog[$];
    int          done_n[N];
    int          to_n = 0;
    int          to_stamp = 0;
    logic [31:0] to_data = '0;
    logic [31:0] last_data = '0;
    logic        wr_at_done = 0;
    int          rd_seen = 0;
    int          wr_seen = 0;
    int          ncyc = 0;
    logic [N-1:0] wlow = '0;

    always @(negedge clk) begin
        e_wreq = '1; e_rd = '0; e_addr = '0; e_wd = '0;
        e_wr = 0; e_mrd = 0; e_busy = 0; e_to = 0;
        pend = req_rd | req_wr;
        if (!rst_n) begin
            m_issue = 0; m_g = 0; m_wait = 0; m_last = N - 1;
        end else if (!m_issue) begin
            for (int s = 1; s <= N; s++) begin
                if (!m_issue && pend[(m_last + s) % N]) begin
                    m_issue = 1;
                    m_g = (m_last + s) % N;
                    m_wait = 0;
                end
            end
        end else begin
            e_busy = 1;
            e_addr = req_addr[m_g*8 +: 8];
            e_wd   = req_wdata[m_g*32 +: 32];
            e_wr   = req_wr[m_g];
            e_mrd  = req_rd[m_g] && !req_wr[m_g];
            if (!mac_wait) begin
                e_wreq[m_g] = 0; e_rd = mac_rdata;
                m_last = m_g; m_issue = 0;
            end else if (m_wait == TO) begin
                e_wr = 0; e_mrd = 0; e_wreq[m_g] = 0;
                e_rd = ERR; e_to = 1;
                m_last = m_g; m_issue = 0;
            end else if (!pend[m_g]) begin
                m_issue = 0;
            end else begin
                m_wait++;
            end
        end
        chk("waitrequest", 64'(wreq), 64'(e_wreq));
        chk("rd_data", 64'(rd_data), 64'(e_rd));
        chk("mac_addr", 64'(mac_addr), 64'(e_addr));
        chk("mac_wr_data", 64'(mac_wdata), 64'(e_wd));
        chk("mac_wr", 64'(mac_wr), 64'(e_wr));
        chk("mac_rd", 64'(mac_rd), 64'(e_mrd));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("timeout", 64'(tmo), 64'(e_to));
        for (int k = 0; k < N; k++) begin
            wlow[k] = !wreq[k];
            if (!wreq[k]) begin
                glog.push_back(k);
                done_n[k]++;
                last_data = rd_data;
                wr_at_done = mac_wr;
            end
        end
        if (tmo) begin
            to_n++; to_stamp = ncyc; to_data = rd_data;
        end
        if (mac_rd) rd_seen++;
        if (mac_wr) wr_seen++;
        ncyc++;
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clr_log();
        glog.delete();
        for (int k = 0; k < N; k++) done_n[k] = 0;
        to_n = 0; rd_seen = 0; wr_seen = 0;
    endtask

    task automatic set_req(input int k, input logic rd, input logic wr,
                           input logic [7:0] a, input logic [31:0] d);
        req_rd[k] = rd;
        req_wr[k] = wr;
        req_addr[k*8 +: 8] = a;
        req_wdata[k*32 +: 32] = d;
    endtask

    task automatic rst_pulse();
        req_rd = '0; req_wr = '0;
        rst_n = 0;
        cyc(2);
        rst_n = 1;
    endtask

    bit   act[N];
    int   burst;
    int   t0;
    logic [1:0] r;

    initial begin
        // Reset state
        cyc(2);
        chk("rst_waitrequest", 64'(wreq), 64'(2'b11));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_mac_strobes", 64'({mac_wr, mac_rd}), 64'(0));
        rst_n = 1;
        cyc(1);

        // Single read with a 3-cycle MAC stall
        clr_log();
        set_req(0, 1, 0, 8'h01, 32'h0);
        mac_wait = 1;
        cyc(4);
        mac_wait = 0; mac_rdata = 32'h0000_796D;
        cyc(1);
        req_rd = '0; mac_wait = 1; mac_rdata = '0;
        cyc(3);
        chk("t1_done0", 64'(done_n[0]), 64'(1));
        chk("t1_data", 64'(last_data), 64'h0000_796D);
        chk("t1_done1", 64'(done_n[1]), 64'(0));

        // Continuous writes from both, zero-wait MAC
        rst_pulse();
        clr_log();
        mac_wait = 0;
        set_req(0, 0, 1, 8'h10, 32'hAAAA_0000);
        set_req(1, 0, 1, 8'h20, 32'hBBBB_1111);
        cyc(8);
        req_wr = '0;
        chk("t2_count", 64'(glog.size()), 64'(4));
        if (glog.size() == 4) begin
            chk("t2_g0", 64'(glog[0]), 64'(0));
            chk("t2_g1", 64'(glog[1]), 64'(1));
            chk("t2_g2", 64'(glog[2]), 64'(0));
            chk("t2_g3", 64'(glog[3]), 64'(1));
        end
        cyc(2);

        // Timeout abort, then next requester served
        rst_pulse();
        clr_log();
        mac_wait = 1;
        set_req(0, 1, 0, 8'h33, 32'h0);
        set_req(1, 1, 0, 8'h44, 32'h0);
        t0 = ncyc;
        cyc(17);
        req_rd[0] = 0;
        mac_wait = 0; mac_rdata = 32'h0000_1234;
        cyc(2);
        req_rd = '0; mac_wait = 1;
        cyc(2);
        chk("t3_to_count", 64'(to_n), 64'(1));
        chk("t3_to_cycle", 64'(to_stamp - t0), 64'(16));
        chk("t3_to_data", 64'(to_data), 64'hFFFF_FFFF);
        chk("t3_next_data", 64'(last_data), 64'h0000_1234);
        chk("t3_count", 64'(glog.size()), 64'(2));
        if (glog.size() == 2)
            chk("t3_order", 64'({glog[0][3:0], glog[1][3:0]}), 64'h01);

        // rd and wr together: write wins
        clr_log();
        set_req(0, 1, 1, 8'h55, 32'h0000_A5A5);
        mac_wait = 1;
        cyc(2);
        mac_wait = 0;
        cyc(1);
        req_rd = '0; req_wr = '0; mac_wait = 1;
        cyc(2);
        chk("t4_rd_seen", 64'(rd_seen), 64'(0));
        chk("t4_wr_seen", 64'(wr_seen), 64'(2));
        chk("t4_done_as_wr", 64'({done_n[0][3:0], wr_at_done}), 64'h2 + 64'h1);

        // Requester 1 withdraws in its 2nd ISSUE cycle
        clr_log();
        mac_wait = 1;
        set_req(1, 1, 0, 8'h66, 32'h0);
        cyc(1);
        set_req(0, 1, 0, 8'h77, 32'h0);
        cyc(1);
        req_rd[1] = 0;
        cyc(1);
        #3;
        chk("t5_busy_idle", 64'(busy), 64'(0));
        #(-3 + 3);
        cyc(1);
        mac_wait = 0; mac_rdata = 32'h0BAD_F00D;
        cyc(1);
        req_rd = '0; mac_wait = 1;
        cyc(2);
        chk("t5_timeout", 64'(to_n), 64'(0));
        chk("t5_done1", 64'(done_n[1]), 64'(0));
        chk("t5_count", 64'(glog.size()), 64'(1));
        if (glog.size() == 1) chk("t5_g0", 64'(glog[0]), 64'(0));

        // Reset while the MAC stalls a read
        clr_log();
        mac_wait = 1;
        set_req(0, 1, 0, 8'h88, 32'h0);
        set_req(1, 1, 0, 8'h99, 32'h0);
        cyc(3);
        #1;
        chk("t6_pre_rd", 64'(mac_rd), 64'(1));
        rst_n = 0;
        #1;
        chk("t6_rst_rd", 64'(mac_rd), 64'(0));
        chk("t6_rst_wreq", 64'(wreq), 64'(2'b11));
        chk("t6_no_done", 64'(glog.size()), 64'(0));
        cyc(2);
        rst_n = 1;
        clr_log();
        mac_wait = 0;
        cyc(3);
        req_rd = '0; mac_wait = 1;
        chk("t6_first_nonempty", 64'(glog.size() >= 1), 64'(1));
        if (glog.size() >= 1) chk("t6_first", 64'(glog[0]), 64'(0));
        cyc(2);

        // Randomized traffic
        rst_pulse();
        burst = 0;
        for (int k = 0; k < N; k++) act[k] = 0;
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < N; k++) begin
                if (act[k] && wlow[k]) act[k] = 0;
                else if (act[k] && $urandom_range(0, 29) == 0) act[k] = 0;
                if (!act[k]) begin
                    req_rd[k] = 0; req_wr[k] = 0;
                    if ($urandom_range(0, 1) == 1) begin
                        act[k] = 1;
                        r = 2'($urandom_range(1, 3));
                        set_req(k, r[0], r[1], 8'($urandom), $urandom);
                    end
                end
            end
            if (burst > 0) begin
                burst--;
                mac_wait = 1;
            end else begin
                if ($urandom_range(0, 99) == 0) burst = $urandom_range(10, 25);
                mac_wait = ($urandom_range(0, 99) < 50);
            end
            mac_rdata = $urandom;
            cyc(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_ctrl_arb.md
# mac_ctrl_arb

Round-robin arbiter that shares the single MAC control/status register port (8-bit address, 32-bit data, waitrequest handshake) between several register masters. The masters are the PHY init sequencer, a link-status poller and a host-command path. It sits between those masters and the MAC register port in the top level, in the `sys_clk` domain. It serialises their transactions, holds the grant until the MAC completes, and aborts transactions the MAC never completes.

## Interface
Parameters:
- N_REQ, 2, number of requesters (2..4)
- ADDR_W, 8, register address width
- DATA_W, 32, register data width
- TIMEOUT, 1023, cycles of MAC waitrequest tolerated before abort (≥1)
- ERR_DATA, 32'hFFFF_FFFF, read data returned on abort

Ports:
- clk  in  1  system clock (sys_clk)
- rst_n  in  1  asynchronous reset, active low
- i_req_addr  in  N_REQ*ADDR_W  per-requester address, requester k at slice k
- i_req_wr_data  in  N_REQ*DATA_W  per-requester write data
- i_req_wr  in  N_REQ  per-requester write strobe
- i_req_rd  in  N_REQ  per-requester read strobe
- o_req_rd_data  out  DATA_W  read data, shared, valid with the granted requester's waitrequest low
- o_req_waitrequest  out  N_REQ  per-requester waitrequest
- o_mac_addr  out  ADDR_W  to MAC address
- o_mac_wr_data  out  DATA_W  to MAC writedata
- o_mac_wr  out  1  to MAC write
- o_mac_rd  out  1  to MAC read
- i_mac_rd_data  in  DATA_W  from MAC readdata
- i_mac_waitrequest  in  1  from MAC waitrequest
- o_busy  out  1  high in ISSUE
- o_timeout  out  1  one-cycle pulse on abort

## Operation
- Requester protocol:
  - A requester asserts rd or wr with address and data held stable until its o_req_waitrequest is low for one cycle.
  - The transaction completes in that cycle.
- States: IDLE, ISSUE.
- IDLE:
  - A requester is pending when rd | wr is set.
  - If any requester is pending, pick one round-robin, searching from last_grant+1 upward with wrap.
  - Register the pick in grant, clear the timeout counter and go to ISSUE.
  - With nothing pending, stay in IDLE.
- ISSUE, MAC outputs:
  - o_mac_addr and o_mac_wr_data are muxed from requester grant.
  - o_mac_wr = wr[grant].
  - o_mac_rd = rd[grant] & ~wr[grant]; write wins if both strobes are set.
- ISSUE, exits:
  - Completion, i_mac_waitrequest low: o_req_waitrequest[grant] low this cycle, o_req_rd_data = i_mac_rd_data, last_grant ← grant, go to IDLE.
  - Timeout, counter reaches TIMEOUT with waitrequest still high: o_mac_rd/o_mac_wr forced low this cycle, o_req_waitrequest[grant] low, o_req_rd_data = ERR_DATA, o_timeout high, last_grant ← grant, go to IDLE.
  - Requester withdrawal, rd[grant] and wr[grant] both low in ISSUE: return to IDLE with no completion and no o_timeout; last_grant unchanged.
- Outside the completing cycle:
  - o_req_waitrequest is high for every requester.
  - o_req_rd_data = 0.
- In IDLE, o_mac_* are all zero.
- Reset values: state IDLE, grant 0, last_grant N_REQ-1 (so requester 0 wins first), counter 0. Outputs: o_req_waitrequest all ones, o_mac_* 0, o_req_rd_data 0, o_busy 0, o_timeout 0.
- Reset mid-ISSUE: the MAC strobes drop asynchronously and the transaction is not completed toward the requester.

## Timing
- The request is sampled in IDLE at cycle 0; o_mac_rd/o_mac_wr are asserted from cycle 1.
- Minimum latency is 2 cycles from request to waitrequest low, when the MAC does not stall.
- One mandatory IDLE cycle follows every completion or abort, so throughput is at most one transaction per 2 cycles.
- Timeout counter:
  - Width $clog2(TIMEOUT+1).
  - Increments each ISSUE cycle with i_mac_waitrequest high.
  - Abort occurs in the ISSUE cycle where counter == TIMEOUT, which is ISSUE cycle TIMEOUT+1.
  - No wrap.
- The arbitration pointer advances only on completion or abort, so a continuously requesting master cannot starve the others: each pending requester is served within N_REQ transactions.
- Completion and withdrawal in the same cycle count as completion.

## Structure
- Package mac_ctrl_pkg holds:
  - the state enum (ST_IDLE, ST_ISSUE);
  - MAC_ADDR_W = 8 and MAC_DATA_W = 32;
  - the default ERR_DATA constant.
- Sub-module rr_pick (combinational): inputs pending vector and last_grant; outputs index and valid. It is reusable by other arbiters in the design.
- Datapath muxes, the FSM and the timeout counter are in mac_ctrl_arb.

## Test plan
- Single read, requester 0 at addr 8'h01: MAC holds waitrequest for 3 cycles, then returns 32'h0000_796D. Required: requester 0 waitrequest low exactly once with rd_data 32'h0000_796D; requester 1 waitrequest stays high throughout.
- Both requesters write continuously (MAC zero-wait): grants alternate 0,1,0,1 starting with 0, one completion every 2 cycles, o_mac_wr_data matches the granted slice.
- MAC never drops waitrequest, TIMEOUT=15: abort in ISSUE cycle 16, o_timeout pulses once, rd_data = 32'hFFFF_FFFF; the next requester is granted afterwards.
- Requester asserts rd and wr together: only o_mac_wr is asserted, and the transaction completes as a write.
- Requester 1 drops rd in its 2nd ISSUE cycle: state returns to IDLE, no o_timeout, requester 0 pending is granted next.
- rst_n asserted during ISSUE with MAC stalling: o_mac_rd falls immediately, all o_req_waitrequest high, and after release requester 0 wins first.
